// File: rtl/ad5592_pkg.sv
// Shared constants, frame field positions and FSM state type for the
// AD5592 serial-interface responder.
package ad5592_pkg;

    // Control-register addresses with special meaning
    localparam logic [3:0] ADDR_ADC_SEQ = 4'b0010;
    localparam logic [3:0] ADDR_NOP     = 4'b0000;

    // Field positions inside a 16-bit frame
    localparam int DAC_FLAG = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 11;
    localparam int CH_MSB   = 14;
    localparam int CH_LSB   = 12;

    // Number of SCLK rising edges that make a valid frame
    localparam logic [4:0] FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Next set bit of mask strictly after cur, wrapping 7 -> 0. Passing
    // cur = 7 yields the lowest set bit; a single-bit mask returns cur.
    function automatic logic [2:0] next_set_bit(input logic [7:0] mask,
                                                input logic [2:0] cur);
        logic [2:0] idx;
        logic       found;
        next_set_bit = cur;
        found        = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && mask[idx]) begin
                next_set_bit = idx;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by a
// rising/falling edge detector in the clk domain.
module spi_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchronizer chain and keep the previous
    // synchronized value for edge detection. Reset value matches the idle
    // level of the pin so no spurious edge appears after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ad5592_spi_slave.sv
// AD5592-style SPI responder: oversamples the SPI pins, decodes 16-bit
// DAC / control / ADC-sequence frames and returns ADC results on MISO
// one frame after the conversion is captured.
module ad5592_spi_slave
    import ad5592_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADC_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_csn,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic [8*ADC_W-1:0]   adc_data,
    output logic                 dac_wr_en,
    output logic [2:0]           dac_wr_ch,
    output logic [ADC_W-1:0]     dac_wr_data,
    output logic                 reg_wr_en,
    output logic [3:0]           reg_addr,
    output logic [10:0]          reg_data,
    output logic [7:0]           adc_seq,
    output logic                 adc_conv_en,
    output logic [2:0]           adc_conv_ch,
    output logic                 frame_err
);

    // Synchronized pin levels and edge events
    logic w_csn_s,  w_csn_rise,  w_csn_fall;
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (spi_csn),
        .o_q    (w_csn_s),
        .o_rise (w_csn_rise),
        .o_fall (w_csn_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (spi_clk),
        .o_q    (w_sclk_s),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (spi_mosi),
        .o_q    (w_mosi_s),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    // Only the SCLK edges and the MOSI level are needed
    assign w_unused = ^{w_sclk_s, w_mosi_rise, w_mosi_fall};

    state_t              r_state;
    logic [4:0]          r_bit_cnt;
    logic [15:0]         r_rx_shift;
    logic [15:0]         r_tx_shift;
    logic [15:0]         r_tx_next;
    logic                r_armed;
    logic [2:0]          r_next_ch;
    logic [7:0]          r_adc_seq;
    logic                r_miso;
    logic                r_dac_wr_en;
    logic [2:0]          r_dac_wr_ch;
    logic [ADC_W-1:0]    r_dac_wr_data;
    logic                r_reg_wr_en;
    logic [3:0]          r_reg_addr;
    logic [10:0]         r_reg_data;
    logic                r_adc_conv_en;
    logic [2:0]          r_adc_conv_ch;
    logic                r_frame_err;

    // Sample of the channel the sequencer points at, and the result word
    // that would be queued for the next frame
    logic [ADC_W-1:0]    w_sample;
    logic [15:0]         w_conv_word;
    logic                w_sclk_active;

    assign w_sample      = adc_data[int'(r_next_ch)*ADC_W +: ADC_W];
    assign w_conv_word   = r_armed ? {1'b0, r_next_ch, w_sample} : 16'h0000;
    assign w_sclk_active = (r_state == ST_SHIFT) && !w_csn_s;

    // Frame FSM: shift in/out during SHIFT, act on the frame in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_next     <= '0;
            r_armed       <= 1'b0;
            r_next_ch     <= '0;
            r_adc_seq     <= '0;
            r_miso        <= 1'b0;
            r_dac_wr_en   <= 1'b0;
            r_dac_wr_ch   <= '0;
            r_dac_wr_data <= '0;
            r_reg_wr_en   <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_data    <= '0;
            r_adc_conv_en <= 1'b0;
            r_adc_conv_ch <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_dac_wr_en   <= 1'b0;
            r_reg_wr_en   <= 1'b0;
            r_adc_conv_en <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) begin
                        r_bit_cnt  <= '0;
                        r_tx_shift <= r_tx_next;
                        r_miso     <= r_tx_next[15];
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_csn_rise) begin
                        r_state <= ST_DONE;
                    end else if (w_sclk_active) begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[14:0], w_mosi_s};
                            if (r_bit_cnt != 5'd17) begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                            r_miso     <= r_tx_shift[14];
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (r_bit_cnt != FRAME_BITS) begin
                        r_frame_err <= 1'b1;
                    end else if (!r_rx_shift[DAC_FLAG] &&
                                 r_rx_shift[ADDR_MSB:ADDR_LSB] == ADDR_ADC_SEQ) begin
                        // Sequence write re-arms and drops any pending result
                        r_adc_seq <= r_rx_shift[7:0];
                        r_armed   <= |r_rx_shift[7:0];
                        r_next_ch <= next_set_bit(r_rx_shift[7:0], 3'd7);
                        r_tx_next <= 16'h0000;
                    end else begin
                        if (r_rx_shift[DAC_FLAG]) begin
                            r_dac_wr_en   <= 1'b1;
                            r_dac_wr_ch   <= r_rx_shift[CH_MSB:CH_LSB];
                            r_dac_wr_data <= r_rx_shift[ADC_W-1:0];
                        end else begin
                            r_reg_wr_en <= 1'b1;
                            r_reg_addr  <= r_rx_shift[ADDR_MSB:ADDR_LSB];
                            r_reg_data  <= r_rx_shift[10:0];
                        end
                        // Conversion pipeline: capture now, shift out next frame
                        r_tx_next <= w_conv_word;
                        if (r_armed) begin
                            r_adc_conv_en <= 1'b1;
                            r_adc_conv_ch <= r_next_ch;
                            r_next_ch     <= next_set_bit(r_adc_seq, r_next_ch);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign dac_wr_en   = r_dac_wr_en;
    assign dac_wr_ch   = r_dac_wr_ch;
    assign dac_wr_data = r_dac_wr_data;
    assign reg_wr_en   = r_reg_wr_en;
    assign reg_addr    = r_reg_addr;
    assign reg_data    = r_reg_data;
    assign adc_seq     = r_adc_seq;
    assign adc_conv_en = r_adc_conv_en;
    assign adc_conv_ch = r_adc_conv_ch;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ad5592_spi_slave.sv
// Directed testbench for ad5592_spi_slave: DAC, control and sequence
// frames, conversion pipeline, truncated frame and mid-frame reset.
module tb_ad5592_spi_slave;

    logic         clk;
    logic         rst_n;
    logic         spi_csn;
    logic         spi_clk;
    logic         spi_mosi;
    logic         spi_miso;
    logic [95:0]  adc_data;
    logic         dac_wr_en;
    logic [2:0]   dac_wr_ch;
    logic [11:0]  dac_wr_data;
    logic         reg_wr_en;
    logic [3:0]   reg_addr;
    logic [10:0]  reg_data;
    logic [7:0]   adc_seq;
    logic         adc_conv_en;
    logic [2:0]   adc_conv_ch;
    logic         frame_err;

    int total = 0;
    int bad   = 0;

    // Pulse counters maintained by the monitor; the stimulus takes deltas
    int n_dac = 0, n_reg = 0, n_conv = 0, n_err = 0;
    int s_dac, s_reg, s_conv, s_err;
    logic [2:0]  last_dac_ch;
    logic [11:0] last_dac_data;
    logic [3:0]  last_reg_addr;
    logic [10:0] last_reg_data;
    logic [2:0]  last_conv_ch;
    logic [15:0] rd;

    ad5592_spi_slave #(.SYNC_STAGES(2), .ADC_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_csn     (spi_csn),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .adc_data    (adc_data),
        .dac_wr_en   (dac_wr_en),
        .dac_wr_ch   (dac_wr_ch),
        .dac_wr_data (dac_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .adc_seq     (adc_seq),
        .adc_conv_en (adc_conv_en),
        .adc_conv_ch (adc_conv_ch),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (dac_wr_en) begin
            n_dac++;
            last_dac_ch   = dac_wr_ch;
            last_dac_data = dac_wr_data;
            $display("dac write ch=%0d data=0x%03h", dac_wr_ch, dac_wr_data);
        end
        if (reg_wr_en) begin
            n_reg++;
            last_reg_addr = reg_addr;
            last_reg_data = reg_data;
            $display("reg write addr=0x%0h data=0x%03h", reg_addr, reg_data);
        end
        if (adc_conv_en) begin
            n_conv++;
            last_conv_ch = adc_conv_ch;
            $display("adc conversion ch=%0d", adc_conv_ch);
        end
        if (frame_err) begin
            n_err++;
            $display("frame error pulse");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_dac  = n_dac;
        s_reg  = n_reg;
        s_conv = n_conv;
        s_err  = n_err;
    endtask

    // One SPI frame at 8 clk per bit; MISO captured just before each SCLK
    // falling edge. With close=0 the frame is left open (CSN still low).
    task automatic spi_xfer(input logic [15:0] w, input int nbits, input bit close,
                            output logic [15:0] miso_word);
        miso_word = '0;
        spi_csn   = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = w[15-b];
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            miso_word[15-b] = spi_miso;
            spi_clk = 1'b0;
        end
        spi_mosi = 1'b0;
        if (close) begin
            repeat (4) @(negedge clk);
            spi_csn = 1'b1;
            repeat (12) @(negedge clk);
        end
        $display("frame mosi=0x%04h bits=%0d miso=0x%04h", w, nbits, miso_word);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_csn  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        adc_data = '0;
        adc_data[0*12 +: 12] = 12'h111;
        adc_data[1*12 +: 12] = 12'h0AA;
        adc_data[2*12 +: 12] = 12'h222;
        adc_data[3*12 +: 12] = 12'h333;
        adc_data[7*12 +: 12] = 12'hFFF;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_miso",    32'(spi_miso), 0);
        chk("rst_adc_seq", 32'(adc_seq), 0);
        chk("rst_pulses",  32'({dac_wr_en, reg_wr_en, adc_conv_en, frame_err}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // DAC write
        snap();
        spi_xfer(16'hB5A3, 16, 1'b1, rd);
        chk("dac_cnt",  32'(n_dac - s_dac), 1);
        chk("dac_ch",   32'(last_dac_ch), 3);
        chk("dac_data", 32'(last_dac_data), 32'h5A3);
        chk("dac_miso", 32'(rd), 0);
        chk("dac_noreg", 32'(n_reg - s_reg), 0);

        // Control-register write
        snap();
        spi_xfer(16'h5802, 16, 1'b1, rd);
        chk("reg_cnt",  32'(n_reg - s_reg), 1);
        chk("reg_addr", 32'(last_reg_addr), 32'hB);
        chk("reg_data", 32'(last_reg_data), 32'h002);
        chk("reg_seq",  32'(adc_seq), 0);

        // Sequence write, mask channels 0 and 2
        snap();
        spi_xfer(16'h1005, 16, 1'b1, rd);
        chk("seq_val",   32'(adc_seq), 32'h05);
        chk("seq_noreg", 32'(n_reg - s_reg), 0);
        chk("seq_noconv", 32'(n_conv - s_conv), 0);
        snap();
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq_nop1_miso", 32'(rd), 32'h0000);
        chk("seq_nop1_ch",   32'(last_conv_ch), 0);
        chk("seq_nop1_reg",  32'(n_reg - s_reg), 1);
        chk("seq_nop1_addr", 32'(last_reg_addr), 0);
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq_nop2_miso", 32'(rd), 32'h0111);
        chk("seq_nop2_ch",   32'(last_conv_ch), 2);
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq_nop3_miso", 32'(rd), 32'h2222);
        chk("seq_nop3_ch",   32'(last_conv_ch), 0);
        chk("seq_conv_cnt",  32'(n_conv - s_conv), 3);

        // Re-arm mid-sequence with channel 7 only; the pending ch0 result
        // still goes out on this frame and is then discarded
        snap();
        spi_xfer(16'h1080, 16, 1'b1, rd);
        chk("seq7_wr_miso", 32'(rd), 32'h0111);
        chk("seq7_val",     32'(adc_seq), 32'h80);
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq7_nop1_miso", 32'(rd), 32'h0000);
        chk("seq7_nop1_ch",   32'(last_conv_ch), 7);
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq7_nop2_miso", 32'(rd), 32'h7FFF);
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("seq7_nop3_miso", 32'(rd), 32'h7FFF);
        chk("seq7_conv_cnt",  32'(n_conv - s_conv), 3);

        // Truncated DAC frame (9 bits): error only, pipeline untouched
        snap();
        spi_xfer(16'hC123, 9, 1'b1, rd);
        chk("trunc_err",    32'(n_err - s_err), 1);
        chk("trunc_nodac",  32'(n_dac - s_dac), 0);
        chk("trunc_noconv", 32'(n_conv - s_conv), 0);
        snap();
        spi_xfer(16'hC123, 16, 1'b1, rd);
        chk("post_dac_cnt",  32'(n_dac - s_dac), 1);
        chk("post_dac_ch",   32'(last_dac_ch), 4);
        chk("post_dac_data", 32'(last_dac_data), 32'h123);
        chk("post_miso",     32'(rd), 32'h7FFF);
        chk("post_conv_ch",  32'(last_conv_ch), 7);
        chk("post_err",      32'(n_err - s_err), 0);

        // Reset in the middle of an armed read frame
        snap();
        spi_xfer(16'h0000, 8, 1'b0, rd);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_miso", 32'(spi_miso), 0);
        chk("mrst_seq",  32'(adc_seq), 0);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_nopulse", 32'((n_dac - s_dac) + (n_reg - s_reg) + (n_conv - s_conv) + (n_err - s_err)), 0);
        snap();
        spi_xfer(16'h0000, 16, 1'b1, rd);
        chk("mrst_nop_miso",   32'(rd), 32'h0000);
        chk("mrst_nop_noconv", 32'(n_conv - s_conv), 0);
        chk("mrst_nop_reg",    32'(n_reg - s_reg), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
